player_ctrl: RTL

PLAYER_CTRL -- requirements
Module: player_ctrl

---
 rtl/player_ctrl_pkg.sv | 27 ++
 rtl/player_ctrl_if.sv | 22 ++
 rtl/btn_debounce.sv | 42 ++++
 rtl/player_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/player_ctrl_pkg.sv
// Shared VGA geometry, RGB222 colours and movement-direction encoding for the
// player sprite controller.
package player_ctrl_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam logic [5:0] RGB_BLACK = 6'b000000;
    localparam logic [5:0] RGB_RED   = 6'b110000;
    localparam logic [5:0] RGB_GREEN = 6'b001100;
    localparam logic [5:0] RGB_BLUE  = 6'b000011;
    localparam logic [5:0] RGB_WHITE = 6'b111111;

    typedef enum logic [1:0] {
        DirHold,
        DirLeft,
        DirRight
    } dir_e;

    // Both or neither button pressed means hold.
    function automatic dir_e decode_dir(input logic l, input logic r);
        if (l && !r) return DirLeft;
        if (r && !l) return DirRight;
        return DirHold;
    endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// Buttons and VGA counters in, sprite pixel and position state out.
interface player_ctrl_if;

    logic       pbL;
    logic       pbR;
    logic [9:0] horCnt;
    logic [9:0] verCnt;
    logic [5:0] content;
    logic [9:0] playerPos;
    logic       speedUp;

    modport master (
        output pbL, pbR, horCnt, verCnt,
        input  content, playerPos, speedUp
    );

    modport slave (
        input  pbL, pbR, horCnt, verCnt,
        output content, playerPos, speedUp
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a debouncer: the output level follows the
// synchronised input only after it has held a new value for DB_CYCLES cycles.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/player_ctrl.sv
// Player sprite controller: debounced buttons move the sprite once per frame,
// with double speed after a sustained move, and a registered sprite pixel output.
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int unsigned SCREEN_W    = H_ACTIVE,
    parameter int unsigned PLAYER_W    = 32,
    parameter int unsigned PLAYER_H    = 16,
    parameter int unsigned PLAYER_Y    = 440,
    parameter int unsigned START_POS   = 304,
    parameter int unsigned STEP        = 4,
    parameter int unsigned HOLD_FRAMES = 8,
    parameter int unsigned DB_CYCLES   = 4,
    parameter bit          WRAP        = 1'b0,
    parameter logic [5:0]  COLOR       = RGB_GREEN
) (
    input logic          clk,
    input logic          reset,
    player_ctrl_if.slave bus
);

    localparam logic [10:0] POS_MAX   = 11'(SCREEN_W - PLAYER_W);
    localparam logic [10:0] WRAP_SPAN = 11'(SCREEN_W - PLAYER_W + 1);
    localparam logic [10:0] STEP_1X   = 11'(STEP);
    localparam logic [10:0] STEP_2X   = 11'(2 * STEP);
    localparam logic [10:0] SPR_W     = 11'(PLAYER_W);
    localparam logic [10:0] Y_TOP     = 11'(PLAYER_Y);
    localparam logic [10:0] Y_BOT     = 11'(PLAYER_Y + PLAYER_H);
    localparam logic [10:0] X_LIM     = 11'(SCREEN_W);
    localparam logic [10:0] Y_LIM     = 11'(V_ACTIVE);
    localparam int unsigned HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

    logic              w_btn_l, w_btn_r;
    logic              w_tick_cond, w_tick, w_speed, w_in_box;
    dir_e              w_dir;
    logic [10:0]       w_pos_ext, w_hor_ext, w_ver_ext, w_step;
    logic [10:0]       w_left, w_right, w_pos_next;
    logic [HOLD_W-1:0] w_hold_next;

    logic [9:0]        r_pos;
    logic [HOLD_W-1:0] r_hold;
    dir_e              r_last_dir;
    logic              r_tick_cond;
    logic [5:0]        r_content;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (bus.pbL),
        .o_level (w_btn_l)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (bus.pbR),
        .o_level (w_btn_r)
    );

    // Rising edge of the tick position so a stalled counter cannot retrigger.
    assign w_tick_cond = (bus.horCnt == 10'd0) && (bus.verCnt == 10'(V_ACTIVE));
    assign w_tick      = w_tick_cond && !r_tick_cond;
    assign w_speed     = (r_hold == HOLD_MAX);

    always_comb begin
        w_dir       = decode_dir(w_btn_l, w_btn_r);
        w_pos_ext   = {1'b0, r_pos};
        w_hor_ext   = {1'b0, bus.horCnt};
        w_ver_ext   = {1'b0, bus.verCnt};
        w_step      = w_speed ? STEP_2X : STEP_1X;
        w_left      = w_pos_ext - w_step;
        w_right     = w_pos_ext + w_step;
        w_pos_next  = w_pos_ext;
        w_hold_next = r_hold;

        if (w_pos_ext < w_step) begin
            w_left = WRAP ? (w_pos_ext - w_step + WRAP_SPAN) : 11'd0;
        end
        if (w_right > POS_MAX) begin
            w_right = WRAP ? (w_pos_ext + w_step - WRAP_SPAN) : POS_MAX;
        end

        unique case (w_dir)
            DirLeft:  w_pos_next = w_left;
            DirRight: w_pos_next = w_right;
            default:  w_pos_next = w_pos_ext;
        endcase

        if (w_dir == DirHold) begin
            w_hold_next = '0;
        end else if (w_dir != r_last_dir) begin
            w_hold_next = HOLD_W'(1);
        end else if (r_hold != HOLD_MAX) begin
            w_hold_next = r_hold + HOLD_W'(1);
        end

        w_in_box = (w_hor_ext >= w_pos_ext) && (w_hor_ext < w_pos_ext + SPR_W) &&
                   (w_ver_ext >= Y_TOP) && (w_ver_ext < Y_BOT) &&
                   (w_hor_ext < X_LIM) && (w_ver_ext < Y_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos       <= 10'(START_POS);
            r_hold      <= '0;
            r_last_dir  <= DirHold;
            r_tick_cond <= 1'b0;
            r_content   <= RGB_BLACK;
        end else begin
            r_tick_cond <= w_tick_cond;
            r_content   <= w_in_box ? COLOR : RGB_BLACK;
            if (w_tick) begin
                r_pos      <= w_pos_next[9:0];
                r_hold     <= w_hold_next;
                r_last_dir <= w_dir;
            end
        end
    end

    assign bus.playerPos = r_pos;
    assign bus.content   = r_content;
    assign bus.speedUp   = w_speed;

endmodule
